// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte and frame-status bundle from uart_rx
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_ERR;
    logic             STP_ERR;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_ERR,
        output STP_ERR
    );

    modport slave (
        input P_DATA,
        input DATA_VALID,
        input PAR_ERR,
        input STP_ERR
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority-vote bit decision
module uart_rx #(
    parameter int WIDTH    = 8,
    parameter int PRESC_WD = 6
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RX_IN,
    input  logic [PRESC_WD-1:0] Prescale,
    input  logic                PAR_ENABLE,
    input  logic                PAR_TYPE,
    uart_rx_if.master           rx_bus
);

    localparam int BIT_WD = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic [PRESC_WD-1:0] legal_presc(input logic [PRESC_WD-1:0] p);
        if (p == PRESC_WD'(16) || p == PRESC_WD'(32)) begin
            return p;
        end
        return PRESC_WD'(8);
    endfunction

    logic                sync1_q, sync2_q;
    logic                rx_s;
    state_t              state_q, state_d;
    logic [PRESC_WD-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_WD-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PRESC_WD-1:0] presc_q, presc_d;
    logic                par_en_q, par_en_d;
    logic                par_type_q, par_type_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [1:0]          samp_q, samp_d;
    logic                par_fail_q, par_fail_d;
    logic                break_q, break_d;
    logic [WIDTH-1:0]    p_data_q, p_data_d;
    logic                data_valid_q, data_valid_d;
    logic                par_err_q, par_err_d;
    logic                stp_err_q, stp_err_d;

    logic [PRESC_WD-1:0] half;
    logic                bit_end;
    logic                at_s0, at_s1, at_dec;
    logic                maj;

    assign rx_s = sync2_q;

    // Samples taken just before and at mid-bit; the third is the live line at the decision point
    assign half    = presc_q >> 1;
    assign bit_end = (edge_cnt_q == presc_q - PRESC_WD'(1));
    assign at_s0   = (edge_cnt_q == half - PRESC_WD'(1));
    assign at_s1   = (edge_cnt_q == half);
    assign at_dec  = (edge_cnt_q == half + PRESC_WD'(1));
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = bit_end ? '0 : edge_cnt_q + PRESC_WD'(1);
        bit_cnt_d    = bit_cnt_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_type_d   = par_type_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        par_fail_d   = par_fail_q;
        break_d      = break_q & ~rx_s;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (at_s0) begin
            samp_d[0] = rx_s;
        end
        if (at_s1) begin
            samp_d[1] = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                // A line still low after a stop error is a break, not a new start bit
                if (!rx_s && !break_q) begin
                    state_d    = S_START;
                    presc_d    = legal_presc(Prescale);
                    par_en_d   = PAR_ENABLE;
                    par_type_d = PAR_TYPE;
                    par_fail_d = 1'b0;
                end
            end
            S_START: begin
                if (at_dec && maj) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (at_dec) begin
                    shift_d = {maj, shift_q[WIDTH-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == BIT_WD'(WIDTH - 1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_WD'(1);
                    end
                end
            end
            S_PARITY: begin
                if (at_dec && (maj != ((^shift_q) ^ par_type_q))) begin
                    par_fail_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Resolve at mid stop bit so a following start edge is never missed
                if (at_dec) begin
                    state_d      = S_IDLE;
                    edge_cnt_d   = '0;
                    data_valid_d = maj & ~par_fail_q;
                    par_err_d    = par_fail_q;
                    stp_err_d    = ~maj;
                    break_d      = ~maj;
                    if (maj && !par_fail_q) begin
                        p_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            presc_q      <= PRESC_WD'(8);
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            shift_q      <= '0;
            samp_q       <= 2'b11;
            par_fail_q   <= 1'b0;
            break_q      <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            sync1_q      <= RX_IN;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_type_q   <= par_type_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            par_fail_q   <= par_fail_d;
            break_q      <= break_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign rx_bus.P_DATA     = p_data_q;
    assign rx_bus.DATA_VALID = data_valid_q;
    assign rx_bus.PAR_ERR    = par_err_q;
    assign rx_bus.STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_ENABLE;
    logic       PAR_TYPE;

    uart_rx_if #(.WIDTH(8)) bus ();

    uart_rx #(.WIDTH(8), .PRESC_WD(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_ENABLE (PAR_ENABLE),
        .PAR_TYPE   (PAR_TYPE),
        .rx_bus     (bus)
    );

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    longint     cyc     = 0;
    logic [7:0] last_good = 8'h00;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        exp_t e;
        if (!RST && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got dv/pe/se=%b%b%b at cycle %0d, required no pulse",
                         bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, cyc);
            end else begin
                e = exp_q.pop_front();
                n_tests++;
                if ({bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR} !== {e.dv, e.pe, e.se}) begin
                    n_fail++;
                    $display("FAIL flags: got dv/pe/se=%b%b%b, required %b%b%b",
                             bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, e.dv, e.pe, e.se);
                end
                n_tests++;
                if (bus.P_DATA !== e.data) begin
                    n_fail++;
                    $display("FAIL p_data: got %h, required %h", bus.P_DATA, e.data);
                end
                if (e.cyc >= 0) begin
                    n_tests++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL latency: pulse at cycle %0d, required %0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic align();
        @(posedge CLK);
        #8;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // exp_lat: pulse edge counted from the first edge that samples the start bit; 0 = unchecked
    task automatic send_frame(input logic [7:0] b, input int p, input bit pen, input bit ptype,
                              input bit par_flip, input bit stop_v, input real d,
                              input int exp_lat, input int presc_mid);
        exp_t e;
        real  bt;
        logic pb;
        bt     = real'(p * 10) * (1.0 + d);
        pb     = (^b) ^ ptype ^ par_flip;
        e.pe   = pen & par_flip;
        e.se   = ~stop_v;
        e.dv   = ~e.pe & stop_v;
        e.data = e.dv ? b : last_good;
        if (e.dv) last_good = b;
        e.cyc  = (exp_lat > 0) ? cyc + 1 + exp_lat : -1;
        exp_q.push_back(e);
        RX_IN = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            RX_IN = b[i];
            if (i == 3 && presc_mid != 0) Prescale = presc_mid[5:0];
            #(bt);
        end
        if (pen) begin
            RX_IN = pb;
            #(bt);
        end
        RX_IN = stop_v;
        #(bt);
    endtask

    int   sweep_p[8] = '{8, 16, 32, 8, 16, 32, 8, 16};
    longint g0;

    initial begin
        RST        = 1'b1;
        RX_IN      = 1'b1;
        Prescale   = 6'd8;
        PAR_ENABLE = 1'b0;
        PAR_TYPE   = 1'b0;
        #23;
        check("reset_p_data", 32'(bus.P_DATA), 32'h00);
        check("reset_data_valid", 32'(bus.DATA_VALID), 32'h0);
        check("reset_par_err", 32'(bus.PAR_ERR), 32'h0);
        check("reset_stp_err", 32'(bus.STP_ERR), 32'h0);
        RST = 1'b0;
        repeat (4) @(posedge CLK);

        // Good frame, P=8, no parity: 2 + 9*8 + 4 + 2 = 80
        align();
        send_frame(8'hA5, 8, 0, 0, 0, 1, 0.0, 80, 0);

        // Odd parity at P=16: 2 + 10*16 + 8 + 2 = 172
        Prescale = 6'd16; PAR_ENABLE = 1'b1; PAR_TYPE = 1'b1;
        align();
        send_frame(8'h3C, 16, 1, 1, 0, 1, 0.0, 172, 0);
        send_frame(8'h3C, 16, 1, 1, 1, 1, 0.0, 172, 0);
        align();
        check("p_data_after_par_err", 32'(bus.P_DATA), 32'h3C);

        // Stop error at P=32 (2 + 9*32 + 16 + 2 = 308), then a held-low break
        Prescale = 6'd32; PAR_ENABLE = 1'b0; PAR_TYPE = 1'b0;
        align();
        send_frame(8'h81, 32, 0, 0, 0, 0, 0.0, 308, 0);
        #(32 * 10 * 6);
        check("p_data_after_stp_err", 32'(bus.P_DATA), 32'h3C);
        RX_IN = 1'b1;
        #(32 * 10 * 2);
        align();
        send_frame(8'h7E, 32, 0, 0, 0, 1, 0.0, 308, 0);

        // Three-cycle glitch at P=16; START gives up at edge 2 + 8 + 2
        Prescale = 6'd16;
        align();
        g0 = cyc + 1;
        RX_IN = 1'b0;
        #30;
        RX_IN = 1'b1;
        #93;
        check("glitch_fsm_idle", 32'(dut.state_q), 32'h0);
        check("glitch_edge_ref", 32'(cyc - g0), 32'd12);
        #(16 * 10 * 2);
        align();
        // Back-to-back: 2 + 9*16 + 8 + 2 = 156, second pulse 160 cycles later
        send_frame(8'h00, 16, 0, 0, 0, 1, 0.0, 156, 0);
        send_frame(8'hFF, 16, 0, 0, 0, 1, 0.0, 156, 0);

        // Reset during data bit 3 of a P=8 frame
        Prescale = 6'd8;
        #(16 * 10 * 2);
        align();
        RX_IN = 1'b0; #80;
        RX_IN = 1'b1; #80;
        RX_IN = 1'b0; #80;
        RX_IN = 1'b1; #80;
        RX_IN = 1'b0; #40;
        RST = 1'b1;
        #1;
        check("midreset_p_data", 32'(bus.P_DATA), 32'h00);
        check("midreset_data_valid", 32'(bus.DATA_VALID), 32'h0);
        check("midreset_stp_err", 32'(bus.STP_ERR), 32'h0);
        last_good = 8'h00;
        #20;
        RST = 1'b0;
        RX_IN = 1'b1;
        #(8 * 10 * 3);
        align();
        send_frame(8'h55, 8, 0, 0, 0, 1, 0.0, 80, 0);

        // Prescale changed to 16 mid-frame: frame still runs at 8
        align();
        send_frame(8'hC3, 8, 0, 0, 0, 1, 0.0, 80, 16);
        Prescale = 6'd8;

        // Illegal prescale 12 behaves as 8
        Prescale = 6'd12;
        align();
        send_frame(8'h96, 8, 0, 0, 0, 1, 0.0, 80, 0);

        // Line rate off by +/-3% across prescales and parity settings
        for (int k = 0; k < 8; k++) begin
            logic [7:0] rb;
            bit         pen, pty;
            rb  = 8'($urandom);
            pen = 1'($urandom_range(0, 1));
            pty = 1'($urandom_range(0, 1));
            Prescale   = 6'(sweep_p[k]);
            PAR_ENABLE = pen;
            PAR_TYPE   = pty;
            align();
            send_frame(rb, sweep_p[k], pen, pty, 0, 1, (k % 2 == 0) ? 0.03 : -0.03, 0, 0);
            #(sweep_p[k] * 10 * 2);
        end

        repeat (20) @(posedge CLK);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
